fifo_v1: RTL and testbench
==========================

Name: fifo_v1

Overview:
- Synchronous 16-entry x 4-bit first-in-first-out buffer.
- Everything runs on a single clock, wclk.
- The rclk port is not a clock. It is a read strobe, synchronised into the wclk domain; its rising edges pace reads.
- Sits between a producer writing at the wclk rate and a slower consumer pacing reads via rclk.

Parameters:
- DATA_WIDTH, 4, width of wdata/rdata.
- DEPTH, 16, number of storage entries (power of two).
- ADDR_WIDTH, 4, log2(DEPTH); pointer width.

Ports:
- wclk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wen  input  1  write request, sampled on wclk rising edge.
- wdata  input  DATA_WIDTH  write data, sampled with wen.
- rclk  input  1  asynchronous read strobe; each rising edge permits one read.
- ren  input  1  read enable, qualifies rclk rising edges.
- rdata  output  DATA_WIDTH  registered read data.
- empty  output  1  high when the FIFO holds 0 entries.
- full  output  1  high when the FIFO holds DEPTH entries.

Behaviour:
- Interface: one clock (wclk); reset (rst) is synchronous and active-high.
- Reset, when rst=1 at a wclk edge:
  - write pointer = 0, read pointer = 0, count = 0.
  - rdata = 0, empty = 1, full = 0.
  - rclk synchroniser flops cleared.
  - Memory contents are not cleared.
  - Reset has priority over any simultaneous write or read, including mid-operation; pending data is discarded.
- Read strobe:
  - rclk passes through a 2-flop synchroniser (s1, s2) plus a third flop s3.
  - rd_pulse = s2 & ~s3, one wclk cycle wide per rclk rising edge.
  - Latency from rclk rising edge to rd_pulse is 2-3 wclk edges.
- Write:
  - Occurs at a wclk edge when wen=1 and full=0.
  - mem[wptr] <= wdata; wptr increments modulo DEPTH.
  - When full=1, the write is dropped silently; no state change.
- Read:
  - Occurs at a wclk edge when rd_pulse=1, ren=1 and empty=0.
  - rdata <= mem[rptr]; rptr increments modulo DEPTH.
  - rdata is valid immediately after that edge and holds its value until the next read or reset.
  - When empty=1, the read is ignored and rdata holds.
- Count and flags:
  - count is ADDR_WIDTH+1 bits, range 0..DEPTH.
  - count +1 on a write-only edge, -1 on a read-only edge, unchanged when both or neither occur.
  - empty = (count==0); full = (count==DEPTH). Both are decoded from the registered count, so they change in the same edge as the operation.
- Simultaneous write and read: each is evaluated independently against the flags before the edge.
  - full: only the read proceeds.
  - empty: only the write proceeds; the new entry is not read through in the same cycle.
- Wrap-around: pointers wrap naturally from 15 to 0; ordering is preserved across the wrap.
- Outputs are glitch-free registers or decodes of registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst=1 for 5 wclk cycles -> rdata=0, empty=1, full=0. Release rst -> flags unchanged.
- Fill to full: wen=1 for 16 cycles with wdata 1111,1010,0101,1100 repeated 4 times -> empty drops after the first edge; full=1 after the 16th edge.
- Overflow: a 17th write of 1001 with full=1 -> dropped; full stays 1; count stays 16.
- Drain with paced reads: wen=0, ren=1, rclk toggling every 15 ns with wclk period 20 ns.
  - rdata sequence must be 1111,1010,0101,1100 x4, one value per rclk rising edge; 1001 never appears.
  - full=0 after the first read; empty=1 after the 16th read.
- Underflow: further rclk edges with ren=1 while empty -> rdata holds 1100; empty stays 1.
- Simultaneous and wrap:
  - Write 3 entries, then write and read concurrently for 20 cycles -> count stays constant and order is preserved across the pointer wrap.
  - Assert rst mid-stream -> empty=1, full=0, rdata=0 on the next edge.

Source files
------------

// File: rtl/fifo_v1.sv
`timescale 1ns/1ps
// fifo_v1
//   Synchronous 16 x 4 FIFO clocked by wclk. A producer writes at the wclk
//   rate; a slower consumer paces reads by pulsing rclk, which is treated as
//   a data signal: it is synchronised into wclk and each rising edge opens a
//   one-cycle read slot.
//
// Ports
//   wclk   in   sole clock, all state updates on its rising edge
//   rst    in   synchronous active-high reset (priority over all operations)
//   wen    in   write request
//   wdata  in   write data, sampled with wen
//   rclk   in   asynchronous read strobe, one read per rising edge
//   ren    in   read enable, qualifies the synchronised rclk edge
//   rdata  out  registered read data, holds between reads
//   empty  out  count == 0
//   full   out  count == DEPTH
//
// Handshake: a write is accepted at a wclk edge when wen=1 and full=0, and a
// read when rd_pulse=1, ren=1 and empty=0. Both decisions use the flags as
// they stood before the edge, so a blocked side is dropped without stalling
// the other, and a write into an empty FIFO is never read through in the
// same cycle.
module fifo_v1 #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rclk,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;

  // s1/s2 resolve metastability on the raw strobe; s3 delays s2 by one
  // cycle so the rising edge can be detected as a single-cycle pulse.
  logic s1;
  logic s2;
  logic s3;
  logic rd_pulse;
  logic do_wr;
  logic do_rd;

  assign rd_pulse = s2 & ~s3;
  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign do_wr    = wen & ~full;
  assign do_rd    = rd_pulse & ren & ~empty;

  // Storage is deliberately left out of reset; stale entries are unreachable
  // once the pointers and count are cleared.
  always_ff @(posedge wclk) begin
    if (!rst && do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= rclk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge wclk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdata <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (do_rd) begin
        rdata <= mem[rptr];
        rptr  <= rptr + ADDR_WIDTH'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_v1.sv
`timescale 1ns/1ps
module tb_fifo_v1;

  logic       wclk;
  logic       rst;
  logic       wen;
  logic [3:0] wdata;
  logic       rclk;
  logic       ren;
  logic [3:0] rdata;
  logic       empty;
  logic       full;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] pat[4];
  logic       rst_q;
  logic [3:0] last_rdata;

  fifo_v1 #(.DATA_WIDTH(4), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .wclk  (wclk),
    .rst   (rst),
    .wen   (wen),
    .wdata (wdata),
    .rclk  (rclk),
    .ren   (ren),
    .rdata (rdata),
    .empty (empty),
    .full  (full)
  );

  // ---------------- clock / reset ----------------
  initial begin
    wclk = 1'b0;
    forever #10 wclk = ~wclk;
  end

  always @(posedge wclk) rst_q <= rst;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_data(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Each change of rdata outside reset is one completed read; it must match
  // the oldest expected entry.
  initial begin
    logic [3:0] exp_v;
    forever begin
      @(negedge wclk);
      if (rst_q !== 1'b0) begin
        last_rdata = rdata;
      end else if (rdata !== last_rdata) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected got %b expected no read", rdata);
        end else begin
          exp_v = exp_q.pop_front();
          if (rdata !== exp_v) begin
            errors++;
            $display("FAIL read_order got %b expected %b", rdata, exp_v);
          end
        end
        last_rdata = rdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One rclk pulse aligned so the synchronised pulse lands on the third
  // edge after the rise; the optional write is placed on that same edge.
  task automatic sync_op(input logic do_wr, input logic [3:0] d, input logic do_rd);
    @(posedge wclk); #2;
    rclk = do_rd;
    ren  = 1'b1;
    @(posedge wclk); #2;
    @(posedge wclk); #2;
    rclk  = 1'b0;
    wen   = do_wr;
    wdata = d;
    if (do_wr) exp_q.push_back(d);
    @(posedge wclk); #2;
    wen = 1'b0;
    @(posedge wclk); #2;
  endtask

  task automatic write_cycle(input logic [3:0] d);
    wen   = 1'b1;
    wdata = d;
    exp_q.push_back(d);
    @(posedge wclk); #2;
    wen = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic seen_first;
    logic done;
    pat[0] = 4'b1111;
    pat[1] = 4'b1010;
    pat[2] = 4'b0101;
    pat[3] = 4'b1100;
    rst = 1'b1; wen = 1'b0; wdata = '0; rclk = 1'b0; ren = 1'b0;

    // reset
    repeat (5) @(posedge wclk);
    #2;
    check_data("reset_rdata", rdata, 4'b0000);
    check_bit("reset_empty", empty, 1'b1);
    check_bit("reset_full", full, 1'b0);
    rst = 1'b0;
    @(posedge wclk); #2;
    check_bit("release_empty", empty, 1'b1);
    check_bit("release_full", full, 1'b0);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      wen   = 1'b1;
      wdata = pat[i % 4];
      exp_q.push_back(pat[i % 4]);
      @(posedge wclk); #2;
      if (i == 0) begin
        check_bit("fill_first_empty", empty, 1'b0);
        check_bit("fill_first_full", full, 1'b0);
      end
      if (i == 14) check_bit("fill_15_full", full, 1'b0);
      if (i == 15) check_bit("fill_16_full", full, 1'b1);
    end

    // overflow: dropped, never queued
    wdata = 4'b1001;
    @(posedge wclk); #2;
    wen = 1'b0;
    check_bit("overflow_full", full, 1'b1);
    check_bit("overflow_empty", empty, 1'b0);

    // drain with free-running strobe, 15 ns half period
    ren = 1'b1;
    @(posedge wclk); #3;
    seen_first = 1'b0;
    done       = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      #15 rclk = ~rclk;
      if (!seen_first && rdata !== 4'b0000) begin
        seen_first = 1'b1;
        check_bit("drain_first_full", full, 1'b0);
      end
      if (empty === 1'b1) done = 1'b1;
    end
    check_bit("drain_reached_empty", done, 1'b1);

    // underflow: more strobes while empty
    for (int i = 0; i < 8; i++) #15 rclk = ~rclk;
    rclk = 1'b0;
    repeat (5) @(posedge wclk);
    #2;
    check_data("underflow_rdata", rdata, 4'b1100);
    check_bit("underflow_empty", empty, 1'b1);

    // write and read on the same edge while empty: write only
    sync_op(1'b1, 4'b0110, 1'b1);
    check_data("empty_simul_rdata", rdata, 4'b1100);
    check_bit("empty_simul_empty", empty, 1'b0);
    sync_op(1'b0, 4'b0000, 1'b1);
    check_data("empty_simul_readback", rdata, 4'b0110);
    check_bit("empty_simul_drained", empty, 1'b1);

    // three entries, then 20 concurrent write+read across the wrap
    for (int k = 0; k < 3; k++) write_cycle(4'((k * 5) + 3));
    for (int k = 3; k < 23; k++) begin
      sync_op(1'b1, 4'((k * 5) + 3), 1'b1);
      check_bit("simul_empty", empty, 1'b0);
      check_bit("simul_full", full, 1'b0);
    end
    check_data("simul_last_rdata", rdata, 4'b0010);

    // reset mid-stream with a write pending: all discarded
    @(posedge wclk); #2;
    exp_q.delete();
    rst   = 1'b1;
    wen   = 1'b1;
    wdata = 4'b0111;
    @(posedge wclk); #2;
    rst = 1'b0;
    wen = 1'b0;
    check_data("midrst_rdata", rdata, 4'b0000);
    check_bit("midrst_empty", empty, 1'b1);
    check_bit("midrst_full", full, 1'b0);
    @(posedge wclk); #2;
    check_bit("midrst_hold_empty", empty, 1'b1);

    // every expected read must have been observed
    repeat (4) @(posedge wclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads got %0d left expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
